// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the AXI host path
// and the NN engine's read-only fetch port, with saturating transaction counters.
module bram_arbiter #(
  parameter int DATA_BIT_NUM = 32,
  parameter int ADDR_W       = 32
) (
  input  logic                    axi_clk,
  input  logic                    axi_rst,
  input  logic                    axi_req,
  input  logic                    axi_we,
  input  logic [ADDR_W-1:0]       axi_addr,
  input  logic [DATA_BIT_NUM-1:0] axi_wdata,
  output logic [DATA_BIT_NUM-1:0] axi_rdata,
  output logic                    axi_done,
  input  logic                    nn_req,
  input  logic [ADDR_W-1:0]       nn_addr,
  output logic [DATA_BIT_NUM-1:0] nn_rdata,
  output logic                    nn_done,
  output logic                    clk_BRAM,
  output logic                    rst_BRAM,
  output logic                    en_BRAM,
  output logic [3:0]              we_BRAM,
  output logic [31:0]             addr_BRAM,
  output logic [DATA_BIT_NUM-1:0] dout_BRAM,
  input  logic [DATA_BIT_NUM-1:0] din_BRAM,
  output logic                    busy,
  output logic                    owner,
  output logic [15:0]             axi_txn_cnt,
  output logic [15:0]             nn_txn_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t state;
  logic   cur_write;
  logic   grant_nn;

  assign clk_BRAM = axi_clk;
  assign rst_BRAM = axi_rst;

  // On a tie the requester that did not own the last transaction wins.
  always_comb begin
    grant_nn = 1'b0;
    if (nn_req && (!axi_req || !owner)) grant_nn = 1'b1;
  end

  // NOTE: all state and outputs below are registers, so every assignment is
  // non-blocking; blocking here would let later statements see updated values.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state       <= IDLE;
      cur_write   <= 1'b0;
      owner       <= 1'b1;
      busy        <= 1'b0;
      en_BRAM     <= 1'b0;
      we_BRAM     <= 4'h0;
      addr_BRAM   <= '0;
      dout_BRAM   <= '0;
      axi_rdata   <= '0;
      nn_rdata    <= '0;
      axi_done    <= 1'b0;
      nn_done     <= 1'b0;
      axi_txn_cnt <= '0;
      nn_txn_cnt  <= '0;
    end else begin
      axi_done <= 1'b0;
      nn_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (axi_req || nn_req) begin
            owner     <= grant_nn;
            cur_write <= !grant_nn && axi_we;
            addr_BRAM <= grant_nn ? 32'(nn_addr) : 32'(axi_addr);
            if (!grant_nn) dout_BRAM <= axi_wdata;
            en_BRAM   <= 1'b1;
            we_BRAM   <= (!grant_nn && axi_we) ? 4'hF : 4'h0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          en_BRAM <= 1'b0;
          we_BRAM <= 4'h0;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          // din_BRAM carries the read issued during ACCESS.
          if (owner) begin
            if (!cur_write) nn_rdata <= din_BRAM;
            nn_done <= 1'b1;
            if (nn_txn_cnt != 16'hFFFF) nn_txn_cnt <= nn_txn_cnt + 16'd1;
          end else begin
            if (!cur_write) axi_rdata <= din_BRAM;
            axi_done <= 1'b1;
            if (axi_txn_cnt != 16'hFFFF) axi_txn_cnt <= axi_txn_cnt + 16'd1;
          end
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: behavioural BRAM, transaction-schedule model checked
// every cycle, and directed scenarios with literal expectations.
module tb_bram_arbiter;

  logic        axi_clk = 1'b0;
  logic        axi_rst = 1'b1;
  logic        axi_req = 1'b0, axi_we = 1'b0, nn_req = 1'b0;
  logic [31:0] axi_addr = '0, axi_wdata = '0, nn_addr = '0;
  logic [31:0] axi_rdata, nn_rdata, addr_BRAM, dout_BRAM;
  logic [31:0] din_BRAM = '0;
  logic        axi_done, nn_done, clk_BRAM, rst_BRAM, en_BRAM, busy, owner;
  logic [3:0]  we_BRAM;
  logic [15:0] axi_txn_cnt, nn_txn_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 axi_clk = ~axi_clk;

  bram_arbiter #(.DATA_BIT_NUM(32), .ADDR_W(32)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .axi_req(axi_req), .axi_we(axi_we), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .axi_rdata(axi_rdata), .axi_done(axi_done),
    .nn_req(nn_req), .nn_addr(nn_addr), .nn_rdata(nn_rdata), .nn_done(nn_done),
    .clk_BRAM(clk_BRAM), .rst_BRAM(rst_BRAM), .en_BRAM(en_BRAM), .we_BRAM(we_BRAM),
    .addr_BRAM(addr_BRAM), .dout_BRAM(dout_BRAM), .din_BRAM(din_BRAM),
    .busy(busy), .owner(owner), .axi_txn_cnt(axi_txn_cnt), .nn_txn_cnt(nn_txn_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural BRAM: write or read-with-one-cycle-latency when enabled.
  logic [31:0] bram [logic [31:0]];
  always @(posedge axi_clk) begin
    if (en_BRAM) begin
      if (we_BRAM == 4'hF) bram[addr_BRAM] = dout_BRAM;
      else din_BRAM <= bram.exists(addr_BRAM) ? bram[addr_BRAM] : 32'h0;
    end
  end

  // Model: a granted transaction occupies exactly four cycles; effects are
  // scheduled by the number of edges since the grant.
  int          cyc = 0;
  int          age = 3;
  bit          model_on = 1'b0;
  bit          preset_nn = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic        m_nn, m_write;
  logic [31:0] m_rd;
  logic        e_busy, e_owner, e_en, e_axi_done, e_nn_done;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_dout, e_axi_rdata, e_nn_rdata;
  logic [15:0] e_axi_cnt, e_nn_cnt;

  always @(posedge axi_clk) begin
    cyc++;
    if (axi_rst) begin
      model_on = 1'b1;
      age = 3;
      e_busy = 0; e_owner = 1; e_en = 0; e_we = 0; e_addr = 0; e_dout = 0;
      e_axi_done = 0; e_nn_done = 0; e_axi_rdata = 0; e_nn_rdata = 0;
      e_axi_cnt = 0; e_nn_cnt = 0;
    end else begin
      e_en = 0; e_we = 0; e_axi_done = 0; e_nn_done = 0;
      if (preset_nn) e_nn_cnt = 16'hFFFE;
      if (age < 3) begin
        age++;
        if (age == 2) begin
          if (m_nn) begin
            e_nn_done = 1; e_nn_rdata = m_rd;
            if (e_nn_cnt != 16'hFFFF) e_nn_cnt++;
          end else begin
            e_axi_done = 1;
            if (!m_write) e_axi_rdata = m_rd;
            if (e_axi_cnt != 16'hFFFF) e_axi_cnt++;
          end
        end
        e_busy = (age < 3);
      end else if (axi_req || nn_req) begin
        m_nn    = (axi_req && nn_req) ? !e_owner : nn_req;
        m_write = !m_nn && axi_we;
        e_owner = m_nn;
        e_addr  = m_nn ? nn_addr : axi_addr;
        if (!m_nn) e_dout = axi_wdata;
        if (m_write) mem[e_addr] = axi_wdata;
        m_rd    = mem.exists(e_addr) ? mem[e_addr] : 32'h0;
        e_en    = 1;
        e_we    = m_write ? 4'hF : 4'h0;
        e_busy  = 1;
        age     = 0;
      end
    end
  end

  // Per-cycle comparison plus event logs for the directed checks.
  typedef struct { bit nn; int cyc; } done_ev_t;
  done_ev_t done_log[$];
  int nn_done_cnt = 0;
  int we_cycles   = 0;

  always @(negedge axi_clk) begin
    if (model_on) begin
      check("busy", busy, e_busy);
      check("owner", owner, e_owner);
      check("en_BRAM", en_BRAM, e_en);
      check("we_BRAM", we_BRAM, e_we);
      check("addr_BRAM", addr_BRAM, e_addr);
      check("dout_BRAM", dout_BRAM, e_dout);
      check("axi_done", axi_done, e_axi_done);
      check("nn_done", nn_done, e_nn_done);
      check("axi_rdata", axi_rdata, e_axi_rdata);
      check("nn_rdata", nn_rdata, e_nn_rdata);
      check("axi_txn_cnt", axi_txn_cnt, e_axi_cnt);
      check("nn_txn_cnt", nn_txn_cnt, e_nn_cnt);
      check("rst_BRAM", rst_BRAM, axi_rst);
    end
    if (axi_done) done_log.push_back('{nn: 1'b0, cyc: cyc});
    if (nn_done) begin
      done_log.push_back('{nn: 1'b1, cyc: cyc});
      nn_done_cnt++;
    end
    if (we_BRAM != 4'h0) we_cycles++;
  end

  task automatic step();
    @(posedge axi_clk);
    #2;
  endtask

  // Counts edges from the request until the requester's done is seen.
  task automatic wait_done(input bit nn, input int first, output int lat);
    lat = -1;
    for (int i = first; i <= 12; i++) begin
      @(posedge axi_clk);
      #1;
      if (nn ? nn_done : axi_done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, n, nn0, we0;
    repeat (3) step();
    check("reset_busy", busy, 0);
    check("reset_owner", owner, 1);
    check("reset_en", en_BRAM, 0);
    check("reset_axi_cnt", axi_txn_cnt, 0);
    check("reset_nn_cnt", nn_txn_cnt, 0);
    axi_rst = 0;

    // AXI write 0x10 <= 0xDEADBEEF
    step();
    nn0 = nn_done_cnt;
    axi_req = 1; axi_we = 1; axi_addr = 32'h10; axi_wdata = 32'hDEADBEEF;
    @(posedge axi_clk); #1;
    check("wr_access_en", en_BRAM, 1);
    check("wr_access_we", we_BRAM, 4'hF);
    check("wr_access_addr", addr_BRAM, 32'h10);
    wait_done(0, 2, lat);
    check("wr_latency", lat, 3);
    check("wr_axi_cnt", axi_txn_cnt, 1);
    step();
    axi_req = 0; axi_we = 0;
    check("wr_no_nn_done", nn_done_cnt, nn0);

    // NN read of the written word
    step();
    we0 = we_cycles;
    nn_req = 1; nn_addr = 32'h10;
    wait_done(1, 1, lat);
    check("nn_rd_latency", lat, 3);
    check("nn_rd_data", nn_rdata, 32'hDEADBEEF);
    step();
    nn_req = 0;
    check("nn_rd_we_zero", we_cycles, we0);
    check("nn_rd_axi_rdata", axi_rdata, 32'h0);

    // Simultaneous continuous requests after reset alternate AXI, NN, AXI, NN
    axi_rst = 1;
    step(); step();
    axi_rst = 0;
    base = done_log.size();
    axi_req = 1; axi_we = 0; axi_addr = 32'h10;
    nn_req = 1; nn_addr = 32'h20;
    for (int i = 0; i < 40; i++) begin
      @(posedge axi_clk); #1;
      if (done_log.size() - base >= 4) break;
    end
    axi_req = 0; nn_req = 0;
    repeat (6) step();
    n = done_log.size() - base;
    check("rr_done_count", n, 4);
    if (n >= 4) begin
      check("rr_owner0", done_log[base].nn, 0);
      check("rr_owner1", done_log[base + 1].nn, 1);
      check("rr_owner2", done_log[base + 2].nn, 0);
      check("rr_owner3", done_log[base + 3].nn, 1);
      for (int i = 0; i < 3; i++)
        check("rr_spacing", done_log[base + i + 1].cyc - done_log[base + i].cyc, 4);
    end
    check("rr_axi_rdata", axi_rdata, 32'hDEADBEEF);

    // Reset asserted while an NN read is in CAPTURE
    nn_req = 1; nn_addr = 32'h10;
    wait_done(1, 1, lat);
    step();
    nn_req = 0;
    check("pre_rst_nn_rdata", nn_rdata, 32'hDEADBEEF);
    step();
    nn0 = nn_done_cnt;
    nn_req = 1;
    step();
    @(posedge axi_clk); #1;
    check("capture_busy", busy, 1);
    check("capture_en", en_BRAM, 0);
    #1;
    axi_rst = 1; nn_req = 0;
    @(posedge axi_clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_nn_rdata", nn_rdata, 0);
    check("midrst_axi_cnt", axi_txn_cnt, 0);
    check("midrst_nn_cnt", nn_txn_cnt, 0);
    step();
    axi_rst = 0;
    step();
    check("midrst_no_done", nn_done_cnt, nn0);

    // Address change during ACCESS and request drop during CAPTURE
    step();
    axi_req = 1; axi_we = 0; axi_addr = 32'h10;
    @(posedge axi_clk); #1;
    check("chg_access_addr", addr_BRAM, 32'h10);
    #1;
    axi_addr = 32'h44;
    @(posedge axi_clk); #1;
    check("chg_capture_addr", addr_BRAM, 32'h10);
    #1;
    axi_req = 0;
    wait_done(0, 3, lat);
    check("chg_latency", lat, 3);
    check("chg_rdata", axi_rdata, 32'hDEADBEEF);
    step();

    // Saturation of the NN transaction counter
    @(negedge axi_clk); #1;
    force dut.nn_txn_cnt = 16'hFFFE;
    preset_nn = 1;
    step();
    release dut.nn_txn_cnt;
    preset_nn = 0;
    check("sat_preset", nn_txn_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      nn_req = 1; nn_addr = 32'h20 + 32'(i * 4);
      wait_done(1, 1, lat);
      check("sat_latency", lat, 3);
      step();
      nn_req = 0;
      check("sat_cnt", nn_txn_cnt, 16'hFFFF);
    end
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Single-port BRAM arbiter that shares one BRAM between the AXI host path (read/write) and the NN engine (read-only weight/input fetch). It sits between the two requesters and the BRAM primitive, serialises their accesses with round-robin fairness, drives the BRAM enable/write-enable/address/data pins, and returns read data with a one-cycle done pulse per transaction. Saturating per-requester transaction counters support debug and verification.

## Interface

Parameters:
- `DATA_BIT_NUM`, 32: BRAM data width.
- `ADDR_W`, 32: address width; the address is passed to the BRAM unmodified.

Ports:
- `axi_clk`, in, 1: the single clock. All logic is on the rising edge.
- `axi_rst`, in, 1: synchronous, active-high reset.
- `axi_req`, in, 1: AXI-side request level. Held until `axi_done`.
- `axi_we`, in, 1: 1 = write, 0 = read. Sampled at grant.
- `axi_addr`, in, ADDR_W: AXI address. Sampled at grant.
- `axi_wdata`, in, DATA_BIT_NUM: AXI write data. Sampled at grant.
- `axi_rdata`, out, DATA_BIT_NUM: last AXI read result.
- `axi_done`, out, 1: one-cycle completion pulse for AXI.
- `nn_req`, in, 1: NN read request level. Held until `nn_done`.
- `nn_addr`, in, ADDR_W: NN read address. Sampled at grant.
- `nn_rdata`, out, DATA_BIT_NUM: last NN read result.
- `nn_done`, out, 1: one-cycle completion pulse for NN.
- `clk_BRAM`, out, 1: equals `axi_clk`.
- `rst_BRAM`, out, 1: equals `axi_rst`.
- `en_BRAM`, out, 1: BRAM enable.
- `we_BRAM`, out, 4: byte write enables.
- `addr_BRAM`, out, 32: BRAM address.
- `dout_BRAM`, out, DATA_BIT_NUM: write data to the BRAM.
- `din_BRAM`, in, DATA_BIT_NUM: read data from the BRAM. Valid one cycle after the enabled read.
- `busy`, out, 1: high in any state other than IDLE.
- `owner`, out, 1: owner of the current or last transaction; 0 = AXI, 1 = NN.
- `axi_txn_cnt`, out, 16: completed AXI transactions.
- `nn_txn_cnt`, out, 16: completed NN transactions.

## Operation

State machine:
- IDLE → ACCESS → CAPTURE → DONE → IDLE.

IDLE:
- If neither request is high, stay in IDLE.
- If exactly one request is high, grant it.
- If both are high, grant the requester that is not `owner` (round-robin).
- On grant, latch the owner, we, addr and wdata. Force we = 0 for NN.
- Then go to ACCESS.

ACCESS:
- `en_BRAM`=1 and `addr_BRAM`=latched address.
- `we_BRAM`=4'hF for an AXI write, 4'h0 otherwise.
- `dout_BRAM`=latched wdata.

CAPTURE:
- `en_BRAM`=0.
- For reads, register `din_BRAM` into the owner's rdata register. The other requester's rdata is untouched.
- Writes pass through CAPTURE with no capture, so latency is uniform.

DONE:
- Pulse the owner's done for exactly one cycle.
- Increment the owner's counter; it saturates at 16'hFFFF.
- Return to IDLE.

Registered outputs and hold rules:
- `addr_BRAM`, `dout_BRAM` and `owner` hold their last values outside ACCESS.
- rdata registers hold until the same requester's next read completes.

Boundary behaviour:
- A request dropped before grant causes no access.
- A request dropped after grant does not cancel the transaction: it completes and done still pulses.
- Request inputs that change after grant are ignored for the transaction in flight.
- Starvation bound: at most one transaction of the other requester runs between two grants to a requester that is continuously requesting.
- Reset asserted mid-transaction: the next state is IDLE and no done is issued. All outputs take their reset values.

Reset values:
- 0: `axi_rdata`, `nn_rdata`, `axi_done`, `nn_done`, `en_BRAM`, `we_BRAM`, `addr_BRAM`, `dout_BRAM`, `busy`, both counters.
- `owner`=1 (NN), so that the first tie goes to AXI.

## Timing

- Request first seen high in IDLE at cycle T:
  - cycle T+1: ACCESS, BRAM enabled;
  - cycle T+2: CAPTURE, rdata registered at the end of the cycle;
  - cycle T+3: DONE, done=1 and rdata valid.
- Grant-to-done latency is 3 cycles.
- Minimum spacing between grants is 4 cycles.
- rdata is valid in the same cycle as done and stays stable afterwards.
- A requester that registers done drops req at T+4. If its req is still high at T+4 in IDLE, that is treated as a new request.
- Requesters must therefore drop req in the cycle after seeing done.
- `busy` is high in cycles T+1 through T+3.

## Test plan

- Reset, then AXI write addr 0x10 data 0xDEADBEEF:
  - ACCESS at T+1 with `we_BRAM`=4'hF and `addr_BRAM`=0x10;
  - `axi_done` pulse at T+3;
  - `axi_txn_cnt`=1;
  - `nn_done` never asserts.
- NN read of addr 0x10 after that write:
  - `nn_rdata`=0xDEADBEEF with `nn_done` at T+3;
  - `we_BRAM` stays 0 throughout;
  - `axi_rdata` is unchanged.
- `axi_req` and `nn_req` rise in the same cycle after reset, both held continuously:
  - grants alternate AXI, NN, AXI, NN;
  - done pulses are 4 cycles apart.
- Reset asserted in CAPTURE of an NN read:
  - next cycle is IDLE with `busy`=0;
  - no `nn_done`;
  - `nn_rdata`=0 and both counters 0.
- `axi_addr` changes during ACCESS, and `axi_req` drops during CAPTURE:
  - `addr_BRAM` keeps the granted address;
  - `axi_done` still pulses at T+3.
- Force `nn_txn_cnt` to 0xFFFE, then run 3 NN reads: the counter reads 0xFFFF and stays there.
